// File: rtl/dll_pkg.sv
// Shared types for the DLL transmit scheduler: FSM states, source codes
// and the sequence-number width.
package dll_pkg;

    localparam int SEQ_W = 12;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_TLP  = 2'b01,
        S_RPLY = 2'b10
    } state_e;

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_TLP  = 2'b01;
    localparam logic [1:0] SRC_RPLY = 2'b10;
    localparam logic [1:0] SRC_DLLP = 2'b11;

endpackage

// File: rtl/dll_tx_slice.sv
// One-deep valid/ready register slice carrying a granted beat and its
// {sop, eop, src, seq} tags to the DLL packetizer.
module dll_tx_slice
    import dll_pkg::*;
#(
    parameter int DATA_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_sop_i,
    input  logic              in_eop_i,
    input  logic [1:0]        in_src_i,
    input  logic [SEQ_W-1:0]  in_seq_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_sop_o,
    output logic              out_eop_o,
    output logic [1:0]        out_src_o,
    output logic [SEQ_W-1:0]  out_seq_o,
    input  logic              out_ready_i
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              sop_q;
    logic              eop_q;
    logic [1:0]        src_q;
    logic [SEQ_W-1:0]  seq_q;

    assign in_ready_o = !valid_q || out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            src_q   <= SRC_NONE;
            seq_q   <= '0;
        end else if (in_ready_o) begin
            valid_q <= in_valid_i;
            data_q  <= in_data_i;
            sop_q   <= in_sop_i;
            eop_q   <= in_eop_i;
            src_q   <= in_src_i;
            seq_q   <= in_seq_i;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_sop_o   = sop_q;
    assign out_eop_o   = eop_q;
    assign out_src_o   = src_q;
    assign out_seq_o   = seq_q;

endmodule

// File: rtl/dll_tx_scheduler.sv
// DLL TX scheduler: whole-packet arbitration of replay > DLLP > new TLP.
// Define DLL_TX_STARVE_GUARD_EN to bound DLLP runs ahead of a waiting TLP.
module dll_tx_scheduler
    import dll_pkg::*;
#(
    parameter int PIPE_DATA_WIDTH = 256,
    parameter int MAX_DLLP_RUN    = 4
) (
    input  logic                       sclk,
    input  logic                       srst,
    input  logic                       rply_valid_i,
    input  logic                       rply_sop_i,
    input  logic                       rply_eop_i,
    input  logic [PIPE_DATA_WIDTH-1:0] rply_data_i,
    output logic                       rply_ready_o,
    input  logic                       dllp_valid_i,
    input  logic [PIPE_DATA_WIDTH-1:0] dllp_data_i,
    output logic                       dllp_ready_o,
    input  logic                       tlp_valid_i,
    input  logic                       tlp_sop_i,
    input  logic                       tlp_eop_i,
    input  logic [PIPE_DATA_WIDTH-1:0] tlp_data_i,
    output logic                       tlp_ready_o,
    input  logic                       fc_ok_i,
    input  logic                       rb_full_i,
    output logic                       out_valid_o,
    output logic                       out_sop_o,
    output logic                       out_eop_o,
    output logic [PIPE_DATA_WIDTH-1:0] out_data_o,
    output logic [1:0]                 out_src_o,
    output logic [SEQ_W-1:0]           out_seq_o,
    input  logic                       out_ready_i
);

    state_e               state_q, state_d;
    logic [SEQ_W-1:0]     seq_q, seq_d;
    logic                 adv;
    logic                 tlp_elig;
    logic                 tlp_first;
    logic                 gnt_rply, gnt_dllp, gnt_tlp;
    logic                 rply_acc, dllp_acc, tlp_acc;
    logic                 in_valid;
    logic [PIPE_DATA_WIDTH-1:0] in_data;
    logic                 in_sop, in_eop;
    logic [1:0]           in_src;
    logic [SEQ_W-1:0]     in_seq;

    assign tlp_elig = tlp_valid_i && fc_ok_i && !rb_full_i;

`ifdef DLL_TX_STARVE_GUARD_EN
    logic [3:0] run_q, run_d;

    assign tlp_first = tlp_elig && (run_q == 4'(MAX_DLLP_RUN));

    always_comb begin
        run_d = run_q;
        if (!tlp_elig || tlp_acc) begin
            run_d = '0;
        end else if (dllp_acc) begin
            run_d = run_q + 4'd1;
        end
    end
`else
    assign tlp_first = 1'b0;
`endif

    // An open packet locks the grant to its own source until eop.
    always_comb begin
        gnt_rply = 1'b0;
        gnt_dllp = 1'b0;
        gnt_tlp  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rply_valid_i)      gnt_rply = 1'b1;
                else if (tlp_first)    gnt_tlp  = 1'b1;
                else if (dllp_valid_i) gnt_dllp = 1'b1;
                else if (tlp_elig)     gnt_tlp  = 1'b1;
            end
            S_TLP:   gnt_tlp  = 1'b1;
            S_RPLY:  gnt_rply = 1'b1;
            default: ;
        endcase
    end

    assign rply_ready_o = gnt_rply && adv;
    assign dllp_ready_o = gnt_dllp && adv;
    assign tlp_ready_o  = gnt_tlp && adv;

    assign rply_acc = rply_ready_o && rply_valid_i;
    assign dllp_acc = dllp_ready_o && dllp_valid_i;
    assign tlp_acc  = tlp_ready_o && tlp_valid_i;

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        if (rply_acc) state_d = rply_eop_i ? S_IDLE : S_RPLY;
        if (tlp_acc)  state_d = tlp_eop_i ? S_IDLE : S_TLP;
        if (tlp_acc && tlp_sop_i) seq_d = seq_q + 12'd1;
    end

    always_comb begin
        in_valid = rply_acc || dllp_acc || tlp_acc;
        in_data  = '0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_src   = SRC_NONE;
        in_seq   = '0;
        if (rply_acc) begin
            in_data = rply_data_i;
            in_sop  = rply_sop_i;
            in_eop  = rply_eop_i;
            in_src  = SRC_RPLY;
        end else if (dllp_acc) begin
            in_data = dllp_data_i;
            in_sop  = 1'b1;
            in_eop  = 1'b1;
            in_src  = SRC_DLLP;
        end else if (tlp_acc) begin
            in_data = tlp_data_i;
            in_sop  = tlp_sop_i;
            in_eop  = tlp_eop_i;
            in_src  = SRC_TLP;
            // continuation beats reuse the value consumed by their sop
            in_seq  = tlp_sop_i ? seq_q : seq_q - 12'd1;
        end
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            state_q <= S_IDLE;
            seq_q   <= '0;
`ifdef DLL_TX_STARVE_GUARD_EN
            run_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
`ifdef DLL_TX_STARVE_GUARD_EN
            run_q   <= run_d;
`endif
        end
    end

    dll_tx_slice #(
        .DATA_W (PIPE_DATA_WIDTH)
    ) u_slice (
        .clk_i       (sclk),
        .rst_i       (srst),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_sop_i    (in_sop),
        .in_eop_i    (in_eop),
        .in_src_i    (in_src),
        .in_seq_i    (in_seq),
        .in_ready_o  (adv),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_sop_o   (out_sop_o),
        .out_eop_o   (out_eop_o),
        .out_src_o   (out_src_o),
        .out_seq_o   (out_seq_o),
        .out_ready_i (out_ready_i)
    );

`ifndef SYNTHESIS
    a_idle_sop: assert property (@(posedge sclk) disable iff (srst)
        (state_q == S_IDLE && (rply_acc || tlp_acc))
        |-> (rply_acc ? rply_sop_i : tlp_sop_i));
`endif

endmodule

// File: tb/tb_dll_tx_scheduler.sv
// Bench for dll_tx_scheduler: packet-order scoreboard built from the
// arbitration rules, plus directed latency, backpressure and reset steps.
module tb_dll_tx_scheduler;

    localparam int DW     = 256;
    localparam int MAXRUN = 4;
    localparam int OW     = DW + 16;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
    } beat_t;

    typedef logic [OW-1:0] obeat_t;

    logic          sclk = 1'b0;
    logic          srst;
    logic          rply_valid_i, rply_sop_i, rply_eop_i;
    logic [DW-1:0] rply_data_i;
    logic          rply_ready_o;
    logic          dllp_valid_i;
    logic [DW-1:0] dllp_data_i;
    logic          dllp_ready_o;
    logic          tlp_valid_i, tlp_sop_i, tlp_eop_i;
    logic [DW-1:0] tlp_data_i;
    logic          tlp_ready_o;
    logic          fc_ok_i, rb_full_i;
    logic          out_valid_o, out_sop_o, out_eop_o;
    logic [DW-1:0] out_data_o;
    logic [1:0]    out_src_o;
    logic [11:0]   out_seq_o;
    logic          out_ready_i;

    always #5 sclk = ~sclk;

    dll_tx_scheduler #(
        .PIPE_DATA_WIDTH (DW),
        .MAX_DLLP_RUN    (MAXRUN)
    ) dut (
        .sclk         (sclk),
        .srst         (srst),
        .rply_valid_i (rply_valid_i),
        .rply_sop_i   (rply_sop_i),
        .rply_eop_i   (rply_eop_i),
        .rply_data_i  (rply_data_i),
        .rply_ready_o (rply_ready_o),
        .dllp_valid_i (dllp_valid_i),
        .dllp_data_i  (dllp_data_i),
        .dllp_ready_o (dllp_ready_o),
        .tlp_valid_i  (tlp_valid_i),
        .tlp_sop_i    (tlp_sop_i),
        .tlp_eop_i    (tlp_eop_i),
        .tlp_data_i   (tlp_data_i),
        .tlp_ready_o  (tlp_ready_o),
        .fc_ok_i      (fc_ok_i),
        .rb_full_i    (rb_full_i),
        .out_valid_o  (out_valid_o),
        .out_sop_o    (out_sop_o),
        .out_eop_o    (out_eop_o),
        .out_data_o   (out_data_o),
        .out_src_o    (out_src_o),
        .out_seq_o    (out_seq_o),
        .out_ready_i  (out_ready_i)
    );

    // driver queues (what each source still has to offer)
    beat_t         rq[$];
    beat_t         tq[$];
    logic [DW-1:0] dq[$];
    // model queues (packets not yet placed in the expected stream)
    beat_t         mr[$];
    beat_t         mt[$];
    logic [DW-1:0] md[$];
    int            lr[$];
    int            lt[$];
    obeat_t        exq[$];

    int     checks = 0;
    int     failures = 0;
    int     mseq = 0;
    bit     bp_rand = 1'b0;
    bit     stall_force = 1'b0;
    bit     prev_stall = 1'b0;
    obeat_t prev_out = '0;
    int     used;

    task automatic check(input string tag, input obeat_t obs, input obeat_t expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic add_rply(input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = rnd_data();
            b.sop = (i == 0);
            b.eop = (i == len - 1);
            rq.push_back(b);
            mr.push_back(b);
        end
        lr.push_back(len);
    endtask

    task automatic add_tlp(input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = rnd_data();
            b.sop = (i == 0);
            b.eop = (i == len - 1);
            tq.push_back(b);
            mt.push_back(b);
        end
        lt.push_back(len);
    endtask

    task automatic add_dllp();
        logic [DW-1:0] d;
        d = rnd_data();
        dq.push_back(d);
        md.push_back(d);
    endtask

    task automatic emit_rply();
        int    len;
        beat_t b;
        len = lr.pop_front();
        for (int i = 0; i < len; i++) begin
            b = mr.pop_front();
            exq.push_back({b.d, b.sop, b.eop, 2'b10, 12'd0});
        end
    endtask

    task automatic emit_dllp();
        logic [DW-1:0] d;
        d = md.pop_front();
        exq.push_back({d, 1'b1, 1'b1, 2'b11, 12'd0});
    endtask

    task automatic emit_tlp();
        int    len;
        beat_t b;
        len = lt.pop_front();
        for (int i = 0; i < len; i++) begin
            b = mt.pop_front();
            exq.push_back({b.d, b.sop, b.eop, 2'b01, 12'(mseq)});
        end
        mseq = (mseq + 1) % 4096;
    endtask

    // Expected packet order when every request is already pending.
    task automatic order_all();
`ifdef DLL_TX_STARVE_GUARD_EN
        int run = 0;
`endif
        while (lr.size() > 0) emit_rply();
        while (md.size() > 0 || lt.size() > 0) begin
`ifdef DLL_TX_STARVE_GUARD_EN
            if (lt.size() > 0 && run == MAXRUN) begin
                emit_tlp();
                run = 0;
            end else if (md.size() > 0) begin
                emit_dllp();
                run = (lt.size() > 0) ? run + 1 : 0;
            end else begin
                emit_tlp();
                run = 0;
            end
`else
            if (md.size() > 0) emit_dllp();
            else emit_tlp();
`endif
        end
    endtask

    task automatic drive();
        rply_valid_i = rq.size() > 0;
        rply_data_i  = rply_valid_i ? rq[0].d : '0;
        rply_sop_i   = rply_valid_i ? rq[0].sop : 1'b0;
        rply_eop_i   = rply_valid_i ? rq[0].eop : 1'b0;
        dllp_valid_i = dq.size() > 0;
        dllp_data_i  = dllp_valid_i ? dq[0] : '0;
        tlp_valid_i  = tq.size() > 0;
        tlp_data_i   = tlp_valid_i ? tq[0].d : '0;
        tlp_sop_i    = tlp_valid_i ? tq[0].sop : 1'b0;
        tlp_eop_i    = tlp_valid_i ? tq[0].eop : 1'b0;
    endtask

    task automatic cycle();
        obeat_t cur;
        bit     stall, ra, da, ta;
        drive();
        if (bp_rand) out_ready_i = ($urandom_range(0, 3) != 0);
        else out_ready_i = !stall_force;
        @(negedge sclk);
        cur = {out_data_o, out_sop_o, out_eop_o, out_src_o, out_seq_o};
        stall = out_valid_o && !out_ready_i;
        if (stall)
            check("ready_in_stall",
                  OW'({rply_ready_o, dllp_ready_o, tlp_ready_o}), '0);
        if (prev_stall) check("hold_in_stall", cur, prev_out);
        prev_stall = stall;
        prev_out = cur;
        if (out_valid_o && out_ready_i) begin
            if (exq.size() == 0) check("unexpected_beat", OW'(out_valid_o), '0);
            else check("out_beat", cur, exq.pop_front());
        end
        ra = rply_valid_i && rply_ready_o;
        da = dllp_valid_i && dllp_ready_o;
        ta = tlp_valid_i && tlp_ready_o;
        @(posedge sclk);
        #1;
        if (ra) void'(rq.pop_front());
        if (da) void'(dq.pop_front());
        if (ta) void'(tq.pop_front());
    endtask

    task automatic drain(input int budget, output int n);
        n = 0;
        while ((exq.size() + rq.size() + dq.size() + tq.size()) > 0 && n < budget) begin
            cycle();
            n++;
        end
        check("drain_left", OW'(exq.size() + rq.size() + dq.size() + tq.size()), '0);
    endtask

    task automatic check_zero_out(input string tag);
        check({tag, "_ctl"}, OW'({out_valid_o, out_sop_o, out_eop_o, out_src_o, out_seq_o}), '0);
        check({tag, "_data"}, OW'(out_data_o), '0);
    endtask

    initial begin
        srst = 1'b1;
        fc_ok_i = 1'b1;
        rb_full_i = 1'b0;
        out_ready_i = 1'b1;
        drive();
        repeat (3) @(posedge sclk);
        #1;
        check_zero_out("reset");
        check("reset_ready", OW'({rply_ready_o, dllp_ready_o, tlp_ready_o}), '0);
        srst = 1'b0;

        // two TLPs: 5 beats leave in cycles 1..5 after the first accept
        add_tlp(3);
        add_tlp(2);
        emit_tlp();
        emit_tlp();
        drain(50, used);
        check("tlp_latency", OW'(used), OW'(6));

        // replay arrives mid-TLP, waits for eop, follows with no bubble
        add_tlp(4);
        emit_tlp();
        cycle();
        add_rply(2);
        emit_rply();
        drain(50, used);
        check("rply_after_tlp", OW'(used + 1), OW'(7));

        // all three pending at once
        add_rply(2);
        add_dllp();
        add_tlp(2);
        order_all();
        drain(50, used);
        check("prio_cycles", OW'(used), OW'(6));

        // sequence number wraps 4095 -> 0
        for (int i = 0; i < 4096; i++) add_tlp(1);
        order_all();
        drain(5000, used);
        check("wrap_cycles", OW'(used), OW'(4097));

        // 5 stalled cycles mid-packet
        add_tlp(4);
        emit_tlp();
        cycle();
        cycle();
        stall_force = 1'b1;
        repeat (5) cycle();
        stall_force = 1'b0;
        drain(50, used);

        // rb_full blocks a TLP start
        rb_full_i = 1'b1;
        add_tlp(2);
        repeat (5) begin
            cycle();
            check("rbfull_ready", OW'(tlp_ready_o), '0);
            check("rbfull_valid", OW'(out_valid_o), '0);
        end
        rb_full_i = 1'b0;
        emit_tlp();
        drain(50, used);

        // fc_ok low blocks a TLP start
        fc_ok_i = 1'b0;
        add_tlp(1);
        repeat (3) begin
            cycle();
            check("fc_ready", OW'(tlp_ready_o), '0);
        end
        fc_ok_i = 1'b1;
        emit_tlp();
        drain(50, used);

        // gating applies only to the start of a TLP
        add_tlp(3);
        emit_tlp();
        cycle();
        rb_full_i = 1'b1;
        fc_ok_i = 1'b0;
        drain(50, used);
        check("gate_cont_cycles", OW'(used + 1), OW'(4));
        rb_full_i = 1'b0;
        fc_ok_i = 1'b1;

        // continuous DLLPs with a waiting TLP
        repeat (10) add_dllp();
        add_tlp(1);
        order_all();
        drain(100, used);
        check("dllp_run_cycles", OW'(used), OW'(12));

        // randomized mixes under random backpressure
        bp_rand = 1'b1;
        for (int r = 0; r < 20; r++) begin
            repeat ($urandom_range(0, 2)) add_rply($urandom_range(1, 4));
            repeat ($urandom_range(0, 8)) add_dllp();
            repeat ($urandom_range(0, 4)) add_tlp($urandom_range(1, 4));
            order_all();
            drain(3000, used);
        end
        bp_rand = 1'b0;
        repeat (2) cycle();

        // reset in the middle of a TLP
        add_tlp(4);
        emit_tlp();
        cycle();
        cycle();
        rq.delete();
        dq.delete();
        tq.delete();
        mt.delete();
        lt.delete();
        exq.delete();
        drive();
        srst = 1'b1;
        @(posedge sclk);
        #1;
        check_zero_out("mid_reset");
        srst = 1'b0;
        mseq = 0;
        prev_stall = 1'b0;
        add_tlp(2);
        emit_tlp();
        drain(50, used);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dll_tx_scheduler.md
# dll_tx_scheduler

Transmit-side scheduler of the Data Link Layer that shares the single DLL TX datapath among three requesters: replayed TLPs from the retry buffer, DLLPs (ACK/NAK, FC updates) and new TLPs from the Transaction Layer. It grants whole packets and never interleaves beats of two packets. It assigns the 12-bit sequence number to each new TLP and forwards granted beats through a one-deep register slice to the DLL packetizer, which adds SEQ and LCRC.

## Interface
Parameters:
- PIPE_DATA_WIDTH, 256, beat width of every data path
- MAX_DLLP_RUN, 4, consecutive DLLP grants allowed while a TLP is eligible; range 1..15

Ports:
- sclk  in  1  clock
- srst  in  1  synchronous reset, active-high
- rply_valid_i / rply_sop_i / rply_eop_i  in  1 each  replay beat qualifiers
- rply_data_i  in  PIPE_DATA_WIDTH  replay beat
- rply_ready_o  out  1  replay beat accepted when valid & ready
- dllp_valid_i  in  1  single-beat DLLP request
- dllp_data_i  in  PIPE_DATA_WIDTH  DLLP beat
- dllp_ready_o  out  1  DLLP accepted
- tlp_valid_i / tlp_sop_i / tlp_eop_i  in  1 each  new-TLP beat qualifiers
- tlp_data_i  in  PIPE_DATA_WIDTH  new-TLP beat
- tlp_ready_o  out  1  new-TLP beat accepted
- fc_ok_i  in  1  flow-control credits sufficient for a new TLP
- rb_full_i  in  1  retry buffer cannot take another TLP
- out_valid_o / out_sop_o / out_eop_o  out  1 each  packetizer beat qualifiers
- out_data_o  out  PIPE_DATA_WIDTH  packetizer beat
- out_src_o  out  2  00 none, 01 TLP, 10 replay, 11 DLLP
- out_seq_o  out  12  sequence number of the current new TLP; 0 for other sources
- out_ready_i  in  1  packetizer accepts the out beat

## Operation
- The FSM has three states: S_IDLE, S_TLP and S_RPLY.
- Slice free: `adv = !out_valid_o || out_ready_i`. A source ready is asserted only for the granted source and only when adv = 1.
- S_IDLE arbitration is combinational, and the winner's first beat transfers in the same cycle.
- Priority order:
  - replay first;
  - then DLLP;
  - then new TLP, only when eligible: `tlp_valid_i & fc_ok_i & !rb_full_i`.
- Transitions:
  - A replay or TLP beat accepted in S_IDLE with eop = 0 moves to S_RPLY or S_TLP.
  - A beat accepted with eop = 1 (single-beat packet) stays in S_IDLE.
  - A DLLP always stays in S_IDLE.
  - S_TLP and S_RPLY accept only their own source and return to S_IDLE on the accepted eop beat.
- Fairness and gating:
  - An in-flight TLP is never pre-empted by replay or DLLP.
  - fc_ok_i and rb_full_i gate only TLP start, not its continuation beats.
- Sequence numbers:
  - next_seq is 12 bits, reset 0, incremented mod 4096 (4095 -> 0) on each accepted new-TLP sop beat.
  - Each beat of that TLP carries the pre-increment value on out_seq_o.
  - Replay never touches next_seq.
- Protocol violations:
  - A beat accepted in S_IDLE must have sop = 1.
  - A violation is flagged by a simulation assertion only. There is no RTL recovery.

## Timing
- Latency: 1 cycle from source accept to out_valid_o.
- Throughput: 1 beat/cycle. Back-to-back packets have no bubble, because the S_IDLE following an eop accepts a new first beat.
- The out registers load on adv. When out_valid_o & !out_ready_i they hold stable, and all source readies are 0.
- Reset values: all outputs 0, FSM S_IDLE, next_seq 0, DLLP run counter 0.
- Reset mid-packet: the partial packet is abandoned; no eop is emitted.
- Simultaneous requests in S_IDLE: resolved by priority, one grant per cycle.

## Configuration
- With DLL_TX_STARVE_GUARD_EN defined: a 4-bit run counter tracks DLLP grants.
  - It increments on each DLLP grant while a TLP is eligible.
  - It clears on a TLP grant or whenever no TLP is eligible.
  - When it equals MAX_DLLP_RUN, the next S_IDLE arbitration ranks the eligible TLP above DLLP. Replay stays highest.
- Without the macro: strict replay > DLLP > TLP priority, and the counter is absent.

## Structure
- Shared package dll_pkg holds:
  - the state enum: S_IDLE = 2'b00, S_TLP = 2'b01, S_RPLY = 2'b10;
  - the out_src_o encodings;
  - SEQ_W = 12.
- One sub-module, dll_tx_slice: the valid/ready register slice carrying {data, sop, eop, src, seq}.

## Test plan
- After reset, one TLP of 3 beats with fc_ok = 1, out_ready = 1 -> out beats in cycles 1..3, sop on the first, eop on the third, src = 01, seq = 0; the next TLP gets seq = 1.
- A replay request arrives during beat 2 of a 4-beat TLP -> the TLP completes uninterrupted; the replay sop is accepted in the cycle after the TLP eop, with src = 10 and no bubble.
- DLLP, replay and TLP all valid in S_IDLE -> grant order is replay, then DLLP, then TLP.
- 4096 single-beat TLPs -> out_seq_o wraps 4095 -> 0.
- Backpressure: out_ready = 0 for 5 cycles mid-packet -> out_data held stable and all source readies 0; with rb_full = 1 in S_IDLE, no new TLP starts.
- Starvation guard (macro on, MAX_DLLP_RUN = 4), continuous DLLPs plus an eligible TLP -> 4 DLLPs, then the TLP sop, then DLLPs resume. With the macro off, the TLP waits until DLLPs stop.
- srst asserted mid-TLP -> next cycle all outputs 0 and seq restarts at 0.
